// File: rtl/fpu_pkg.sv
// Shared definitions for the FP operation sequencer.
// Contents:
//   - opcode values (these are also the unit indices)
//   - bit positions inside the 5-bit exception flag vector
//   - sequencer state encoding
//   - canonical quiet-NaN generator
package fpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_SQRT = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;

  // Flag vector layout: {NV, DZ, OF, UF, NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [4:0] FLAGS_NONE = 5'b00000;
  localparam logic [4:0] FLAGS_NV   = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Canonical qNaN: sign 0, 8-bit exponent all ones, fraction MSB set.
  // These are the 9 bits ending one below the sign bit, e.g. 0x7FC00000
  // for a 32-bit word.
  function automatic logic [63:0] canon_nan(input int unsigned width);
    return 64'h1FF << (width - 10);
  endfunction

endpackage

// File: rtl/fpu_unit_mux.sv
// Combinational selection of one attached unit's outputs.
// Ports:
//   sel_i         latched opcode / unit index
//   unit_res_i    packed per-unit results, unit k at [k*WIDTH +: WIDTH]
//   unit_flags_i  packed per-unit flags, unit k at [k*5 +: 5]
//   unit_done_i   per-unit done
//   res_o/flags_o/done_o  outputs of the selected unit (zero if sel_i is
//                         not a valid unit index)
module fpu_unit_mux #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 5
) (
  input  logic [2:0]                 sel_i,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_res_i,
  input  logic [NUM_UNITS*5-1:0]     unit_flags_i,
  input  logic [NUM_UNITS-1:0]       unit_done_i,
  output logic [WIDTH-1:0]           res_o,
  output logic [4:0]                 flags_o,
  output logic                       done_o
);

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    done_o  = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (32'(sel_i) == 32'(k)) begin
        res_o   = unit_res_i[k*WIDTH +: WIDTH];
        flags_o = unit_flags_i[k*5 +: 5];
        done_o  = unit_done_i[k];
      end
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issue/retire controller between the host request port and NUM_UNITS FP
// units. One request is latched, the matching unit is activated one-hot,
// its done rising edge (or a timeout) retires the operation, and the result
// is offered over a valid/ready response port. Sticky exception flags
// accumulate every retired response.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_a, req_b, req_op, req_rm      operands, opcode, rounding mode
//   unit_act                          one-hot activate (index = latched op)
//   unit_in1, unit_in2, unit_rm       latched operands / rounding mode
//   unit_done, unit_res, unit_flags   per-unit done, result, flags (packed)
//   unit_cmp                          compare unit {great, eq, less}
//   resp_valid/resp_ready             response handshake
//   resp_data, resp_flags, resp_tmo   result, {NV,DZ,OF,UF,NX}, timeout mark
//   fflags, fflags_clr                sticky flags and their clear
//   busy                              sequencer not idle
//
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both high; valid-side data is held stable until that edge, and
// ready never depends combinationally on valid.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 5,
  parameter int CMP_UNIT  = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_a,
  input  logic [WIDTH-1:0]           req_b,
  input  logic [2:0]                 req_op,
  input  logic [2:0]                 req_rm,
  output logic [NUM_UNITS-1:0]       unit_act,
  output logic [WIDTH-1:0]           unit_in1,
  output logic [WIDTH-1:0]           unit_in2,
  output logic [2:0]                 unit_rm,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
  input  logic [NUM_UNITS*5-1:0]     unit_flags,
  input  logic [2:0]                 unit_cmp,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [4:0]                 resp_flags,
  output logic                       resp_tmo,
  output logic [4:0]                 fflags,
  input  logic                       fflags_clr,
  output logic                       busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] QNAN     = WIDTH'(canon_nan(WIDTH));

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d, rm_q, rm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_prev_q, done_prev_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       flags_q, flags_d;
  logic             tmo_q, tmo_d;
  logic [4:0]       fflags_q, fflags_d;

  logic [WIDTH-1:0] sel_res;
  logic [4:0]       sel_flags;
  logic             sel_done;
  logic             done_edge;
  logic             resp_hs;

  fpu_unit_mux #(
    .WIDTH     (WIDTH),
    .NUM_UNITS (NUM_UNITS)
  ) u_mux (
    .sel_i        (op_q),
    .unit_res_i   (unit_res),
    .unit_flags_i (unit_flags),
    .unit_done_i  (unit_done),
    .res_o        (sel_res),
    .flags_o      (sel_flags),
    .done_o       (sel_done)
  );

  // Only a fresh rising edge retires; a done that was already high when
  // the unit was activated belongs to an older operation.
  assign done_edge = sel_done & ~done_prev_q;
  assign resp_hs   = (state_q == ST_RESP) && resp_ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rm_d        = rm_q;
    cnt_d       = cnt_q;
    done_prev_d = done_prev_q;
    data_d      = data_q;
    flags_d     = flags_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          rm_d = req_rm;
          if (32'(req_op) >= NUM_UNITS) begin
            // No unit behind this opcode: answer at once as invalid.
            data_d  = '0;
            flags_d = FLAGS_NV;
            tmo_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        done_prev_d = sel_done;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        done_prev_d = sel_done;
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        // A done edge on the last counted cycle still wins over timeout.
        if (done_edge) begin
          if (32'(op_q) == CMP_UNIT) begin
            data_d  = WIDTH'(unit_cmp);
            flags_d = sel_flags & FLAGS_NV;
          end else begin
            data_d  = sel_res;
            flags_d = sel_flags;
          end
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = QNAN;
          flags_d = FLAGS_NV;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Clear first, then OR in the retiring flags so a coincident retire
    // is never lost.
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (resp_hs ? flags_q : 5'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rm_q        <= '0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
      data_q      <= '0;
      flags_q     <= '0;
      tmo_q       <= 1'b0;
      fflags_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rm_q        <= rm_d;
      cnt_q       <= cnt_d;
      done_prev_q <= done_prev_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      tmo_q       <= tmo_d;
      fflags_q    <= fflags_d;
    end
  end

  // The activate is decoded from state, so it drops to zero together with
  // the asynchronous reset.
  assign unit_act   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT))
                      ? (NUM_UNITS'(1) << op_q) : '0;
  assign unit_in1   = a_q;
  assign unit_in2   = b_q;
  assign unit_rm    = rm_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = data_q;
  assign resp_flags = flags_q;
  assign resp_tmo   = tmo_q;
  assign fflags     = fflags_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
module tb_fpu_op_sequencer;

  localparam int W   = 32;
  localparam int NU  = 5;
  localparam int TMO = 64;
  localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid, req_ready;
  logic [W-1:0]    req_a, req_b;
  logic [2:0]      req_op, req_rm;
  logic [NU-1:0]   unit_act;
  logic [W-1:0]    unit_in1, unit_in2;
  logic [2:0]      unit_rm;
  logic [NU-1:0]   unit_done;
  logic [NU*W-1:0] unit_res;
  logic [NU*5-1:0] unit_flags;
  logic [2:0]      unit_cmp;
  logic            resp_valid, resp_ready;
  logic [W-1:0]    resp_data;
  logic [4:0]      resp_flags;
  logic            resp_tmo;
  logic [4:0]      fflags;
  logic            fflags_clr;
  logic            busy;

  fpu_op_sequencer #(
    .WIDTH(W), .NUM_UNITS(NU), .CMP_UNIT(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rm(req_rm),
    .unit_act(unit_act), .unit_in1(unit_in1), .unit_in2(unit_in2), .unit_rm(unit_rm),
    .unit_done(unit_done), .unit_res(unit_res), .unit_flags(unit_flags), .unit_cmp(unit_cmp),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flags(resp_flags), .resp_tmo(resp_tmo),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  // ---------------- model FP units ----------------
  // Unit k raises done after it has seen act high for u_lat[k] clock edges
  // (u_lat 0 = never). A stuck-high done can be overlaid until stuck_until.
  int            u_lat [NU];
  int            u_cnt [NU];
  logic [NU-1:0] u_done_q = '0;
  int            cyc = 0;
  int            stuck_until = 0;
  logic [NU-1:0] stuck_sel = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (unit_act[k]) begin
        if (u_cnt[k] < 1000) u_cnt[k] <= u_cnt[k] + 1;
        if (u_lat[k] != 0 && u_cnt[k] + 1 == u_lat[k]) u_done_q[k] <= 1'b1;
      end else begin
        u_cnt[k]    <= 0;
        u_done_q[k] <= 1'b0;
      end
    end
  end

  assign unit_done = u_done_q | ((cyc < stuck_until) ? stuck_sel : '0);

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [4:0] ff_model = '0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One full transaction. force_vals pins the selected unit's result,
  // flags and the compare bits; otherwise everything is random.
  task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] rm, input int lat, input int hold, input logic clr,
                         input int stuck, input logic force_vals, input logic [W-1:0] f_res,
                         input logic [4:0] f_flags, input logic [2:0] f_cmp);
    logic [W-1:0]  exp_data, held;
    logic [4:0]    exp_flags;
    logic          exp_tmo, bad_ready, stable;
    int            exp_lat, n;
    logic [63:0]   exp_act, act_seen;
    logic [W-1:0]  u_res [NU];
    logic [4:0]    u_flg [NU];

    for (int k = 0; k < NU; k++) begin
      u_res[k] = $urandom;
      u_flg[k] = 5'($urandom_range(0, 31));
      u_lat[k] = $urandom_range(1, 8);
    end
    unit_cmp = 3'($urandom_range(0, 7));
    if (force_vals && op < NU) begin
      u_res[op] = f_res;
      u_flg[op] = f_flags;
      unit_cmp  = f_cmp;
    end
    if (op < NU) u_lat[op] = lat;
    for (int k = 0; k < NU; k++) begin
      unit_res[k*W +: W]  = u_res[k];
      unit_flags[k*5 +: 5] = u_flg[k];
    end

    // Reference: what the response must be, from the operation's rules.
    exp_tmo = 1'b0;
    if (op >= NU) begin
      exp_data = '0; exp_flags = 5'b10000; exp_lat = 1; exp_act = 0;
    end else if (lat == 0 || lat > TMO) begin
      exp_data = QNAN; exp_flags = 5'b10000; exp_tmo = 1'b1; exp_lat = TMO + 2;
      exp_act = 64'd1 << op;
    end else if (op == 3'd4) begin
      exp_data = {29'd0, unit_cmp}; exp_flags = u_flg[op] & 5'b10000; exp_lat = lat + 2;
      exp_act = 64'd1 << op;
    end else begin
      exp_data = u_res[op]; exp_flags = u_flg[op]; exp_lat = lat + 2;
      exp_act = 64'd1 << op;
    end
    exp_q.push_back(exp_data);

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    if (stuck > 0 && op < NU) begin
      stuck_sel   = NU'(1) << op;
      stuck_until = cyc + stuck;
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_rm = rm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 3'($urandom); req_rm = 3'($urandom);

    n = 0; bad_ready = 1'b0; act_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) act_seen = 64'(unit_act);
      if (req_ready) bad_ready = 1'b1;
    end while (!resp_valid && n < 200);

    check("act_onehot", act_seen, exp_act);
    check("latency", n, exp_lat);
    check("resp_valid", resp_valid, 1);
    check("resp_data", resp_data, exp_q.pop_front());
    check("resp_flags", resp_flags, exp_flags);
    check("resp_tmo", resp_tmo, exp_tmo);
    check("unit_in1_held", unit_in1, a);
    check("unit_in2_held", unit_in2, b);
    check("unit_rm_held", unit_rm, rm);
    check("act_off_resp", unit_act, 0);
    check("busy_resp", busy, 1);

    held = resp_data; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_data !== held || !resp_valid || req_ready) stable = 1'b0;
    end
    if (hold > 0) check("resp_hold_stable", stable, 1);

    resp_ready = 1'b1; fflags_clr = clr;
    @(posedge clk);
    #1;
    resp_ready = 1'b0; fflags_clr = 1'b0;
    ff_model = (clr ? 5'b0 : ff_model) | exp_flags;
    @(negedge clk);
    check("fflags", fflags, ff_model);
    check("idle_after_hs", {resp_valid, req_ready, busy}, 3'b010);
    check("no_ready_while_busy", bad_ready, 0);
    stuck_sel = '0; stuck_until = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_a = 0; req_b = 0; req_op = 0; req_rm = 0;
    resp_ready = 0; fflags_clr = 0; unit_res = '0; unit_flags = '0; unit_cmp = '0;
    for (int k = 0; k < NU; k++) begin u_lat[k] = 1; u_cnt[k] = 0; end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_unit_act", unit_act, 0);
    check("rst_busy", busy, 0);
    check("rst_fflags", fflags, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_flags_tmo", {resp_flags, resp_tmo}, 0);
    check("rst_latches", {unit_in1, unit_in2, unit_rm}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    // 1.0 + 2.0 with a 3-cycle add unit
    run_txn(3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3, 0, 1'b0, 0,
            1'b1, 32'h4040_0000, 5'b00000, 3'b000);
    // opcode without a unit
    run_txn(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 3'd1, 3, 0, 1'b0, 0,
            1'b0, '0, '0, '0);
    // divider never answers -> timeout
    run_txn(3'd2, 32'h3F80_0000, 32'h0000_0000, 3'd2, 0, 0, 1'b0, 0,
            1'b0, '0, '0, '0);
    // compare 1.0 vs 2.0 -> less; only NV survives; consumer stalls 10 cycles
    run_txn(3'd4, 32'h3F80_0000, 32'h4000_0000, 3'd0, 2, 10, 1'b0, 0,
            1'b1, 32'hDEAD_BEEF, 5'b11111, 3'b001);
    // mul done stuck high from before issue
    run_txn(3'd1, 32'h4040_0000, 32'h4000_0000, 3'd3, 6, 1, 1'b0, 4,
            1'b0, '0, '0, '0);
    // done edge on the last counted WAIT cycle beats the timeout
    run_txn(3'd3, 32'h4080_0000, 32'h0, 3'd4, TMO, 0, 1'b0, 0,
            1'b0, '0, '0, '0);
    // done one cycle too late -> timeout
    run_txn(3'd0, 32'h1, 32'h2, 3'd0, TMO + 1, 0, 1'b0, 0,
            1'b0, '0, '0, '0);

    // asynchronous reset in the middle of WAIT
    u_lat[2] = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'h5; req_b = 32'h6; req_rm = 3'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_in_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_act", unit_act, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fflags", fflags, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    ff_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    run_txn(3'd0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 4, 0, 1'b0, 0,
            1'b1, 32'h4000_0000, 5'b00000, 3'b000);
    // leave NV set, then clear it in the same cycle an NX result retires
    run_txn(3'd7, 32'h0, 32'h0, 3'd0, 1, 0, 1'b0, 0, 1'b0, '0, '0, '0);
    run_txn(3'd1, 32'h3DCC_CCCD, 32'h4120_0000, 3'd0, 2, 0, 1'b1, 0,
            1'b1, 32'h3F80_0000, 5'b00001, 3'b000);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      int r, lat;
      r = $urandom_range(0, 19);
      if (r == 0)      lat = 0;
      else if (r == 1) lat = TMO;
      else             lat = $urandom_range(1, 10);
      run_txn(3'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 7)), lat,
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0,
              1'b0, '0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
